// File: rtl/region_decoder_fsm.sv
// Programmable 68000 bus-cycle decoder: match/mask region table, registered
// chip selects, wait-state timed DTACKn and no-hit BERRn timeout.
module region_decoder_fsm #(
   parameter int unsigned NUM_REGIONS = 16,
   parameter int unsigned ADDR_W      = 24,
   parameter int unsigned MATCH_BITS  = 8,
   parameter int unsigned WAIT_W      = 4,
   parameter int unsigned PRIORITY    = 1,
   parameter int unsigned BERR_CYCLES = 64,
   localparam int unsigned IDX_W      = $clog2(NUM_REGIONS),
   localparam int unsigned CFG_W      = 2*MATCH_BITS + WAIT_W + 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   cfg_we,
   input  logic [IDX_W-1:0]       cfg_idx,
   input  logic [CFG_W-1:0]       cfg_data,
   input  logic                   cpu_as_n,
   input  logic [1:0]             cpu_ds_n,
   input  logic [ADDR_W-1:0]      cpu_word_addr,
   output logic [NUM_REGIONS-1:0] sel_n,
   output logic [IDX_W-1:0]       hit_idx,
   output logic                   hit,
   output logic                   dtack_n,
   output logic                   berr_n
);

   localparam int unsigned BCNT_W = $clog2(BERR_CYCLES) + 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_ACK  = 3'd2,
      S_BERR = 3'd3,
      S_END  = 3'd4
   } state_t;

   // Region table
   logic                  en_q    [NUM_REGIONS];
   logic                  en_d    [NUM_REGIONS];
   logic [WAIT_W-1:0]     wait_q  [NUM_REGIONS];
   logic [WAIT_W-1:0]     wait_d  [NUM_REGIONS];
   logic [MATCH_BITS-1:0] match_q [NUM_REGIONS];
   logic [MATCH_BITS-1:0] match_d [NUM_REGIONS];
   logic [MATCH_BITS-1:0] mask_q  [NUM_REGIONS];
   logic [MATCH_BITS-1:0] mask_d  [NUM_REGIONS];

   // Bus-cycle state
   state_t                state_q, state_d;
   logic [NUM_REGIONS-1:0] sel_n_q, sel_n_d;
   logic [IDX_W-1:0]      hit_idx_q, hit_idx_d;
   logic                  hit_q, hit_d;
   logic                  dtack_n_q, dtack_n_d;
   logic                  berr_n_q, berr_n_d;
   logic [WAIT_W-1:0]     cnt_q, cnt_d;
   logic [BCNT_W-1:0]     bcnt_q, bcnt_d;

   // Decode results
   logic [NUM_REGIONS-1:0] hit_vec_c;
   logic                   any_hit_c;
   logic [IDX_W-1:0]       win_idx_c;
   logic [WAIT_W-1:0]      win_wait_c;
   logic                   go_end_c;
   logic                   addr_unused_c;

   // Only the upper address bits take part in the decode.
   assign addr_unused_c = ^cpu_word_addr[ADDR_W-MATCH_BITS-1:0];

   // Table write: one entry per strobe, accepted in any state.
   always_comb begin
      en_d    = en_q;
      wait_d  = wait_q;
      match_d = match_q;
      mask_d  = mask_q;
      if (cfg_we && (32'(cfg_idx) < NUM_REGIONS)) begin
         en_d[cfg_idx]    = cfg_data[CFG_W-1];
         wait_d[cfg_idx]  = cfg_data[2*MATCH_BITS +: WAIT_W];
         match_d[cfg_idx] = cfg_data[MATCH_BITS +: MATCH_BITS];
         mask_d[cfg_idx]  = cfg_data[0 +: MATCH_BITS];
      end
   end

   // Per-region match and lowest-index winner with its wait count.
   always_comb begin
      hit_vec_c  = '0;
      win_idx_c  = '0;
      win_wait_c = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         hit_vec_c[i] = en_q[i] &&
            ((cpu_word_addr[ADDR_W-1 -: MATCH_BITS] & mask_q[i]) == match_q[i]);
      end
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if (hit_vec_c[i]) begin
            win_idx_c  = IDX_W'(i);
            win_wait_c = wait_q[i];
         end
      end
      any_hit_c = |hit_vec_c;
   end

   // Next state and registered outputs of the bus-cycle FSM.
   always_comb begin
      state_d   = state_q;
      sel_n_d   = sel_n_q;
      hit_idx_d = hit_idx_q;
      hit_d     = hit_q;
      dtack_n_d = dtack_n_q;
      berr_n_d  = berr_n_q;
      cnt_d     = cnt_q;
      bcnt_d    = bcnt_q;
      go_end_c  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!cpu_as_n && (cpu_ds_n != 2'b11)) begin
               hit_d     = any_hit_c;
               hit_idx_d = win_idx_c;
               cnt_d     = win_wait_c;
               bcnt_d    = '0;
               if (any_hit_c) begin
                  state_d = S_WAIT;
                  sel_n_d = (PRIORITY != 0) ? ~(NUM_REGIONS'(1) << win_idx_c) : ~hit_vec_c;
               end else begin
                  state_d = S_BERR;
                  sel_n_d = '1;
               end
            end
         end
         S_WAIT: begin
            if (cpu_as_n) begin
               go_end_c = 1'b1;
            end else if (cnt_q == '0) begin
               state_d   = S_ACK;
               dtack_n_d = 1'b0;
            end else begin
               cnt_d = cnt_q - WAIT_W'(1);
            end
         end
         S_ACK: begin
            if (cpu_as_n) go_end_c = 1'b1;
         end
         S_BERR: begin
            if (cpu_as_n) begin
               go_end_c = 1'b1;
            end else if (berr_n_q) begin
               if (bcnt_q == BCNT_W'(BERR_CYCLES - 1)) berr_n_d = 1'b0;
               else                                    bcnt_d   = bcnt_q + BCNT_W'(1);
            end
         end
         S_END:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Cycle termination: outputs go idle for the END cycle.
      if (go_end_c) begin
         state_d   = S_END;
         sel_n_d   = '1;
         hit_d     = 1'b0;
         hit_idx_d = '0;
         dtack_n_d = 1'b1;
         berr_n_d  = 1'b1;
      end
   end

   // State, output and table registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         sel_n_q   <= '1;
         hit_idx_q <= '0;
         hit_q     <= 1'b0;
         dtack_n_q <= 1'b1;
         berr_n_q  <= 1'b1;
         cnt_q     <= '0;
         bcnt_q    <= '0;
         for (int i = 0; i < NUM_REGIONS; i++) begin
            en_q[i]    <= 1'b0;
            wait_q[i]  <= '0;
            match_q[i] <= '0;
            mask_q[i]  <= '0;
         end
      end else begin
         state_q   <= state_d;
         sel_n_q   <= sel_n_d;
         hit_idx_q <= hit_idx_d;
         hit_q     <= hit_d;
         dtack_n_q <= dtack_n_d;
         berr_n_q  <= berr_n_d;
         cnt_q     <= cnt_d;
         bcnt_q    <= bcnt_d;
         en_q      <= en_d;
         wait_q    <= wait_d;
         match_q   <= match_d;
         mask_q    <= mask_d;
      end
   end

   assign sel_n   = sel_n_q;
   assign hit_idx = hit_idx_q;
   assign hit     = hit_q;
   assign dtack_n = dtack_n_q;
   assign berr_n  = berr_n_q;

endmodule

// File: tb/tb_region_decoder_fsm.sv
// Directed bench for region_decoder_fsm: one instance in priority mode and
// one in all-hits mode share the same stimulus.
module tb_region_decoder_fsm;

   logic        clk;
   logic        reset_n;
   logic        cfg_we;
   logic [3:0]  cfg_idx;
   logic [20:0] cfg_data;
   logic        as_n;
   logic [1:0]  ds_n;
   logic [23:0] addr;

   logic [15:0] p1_sel_n, p0_sel_n;
   logic [3:0]  p1_idx, p0_idx;
   logic        p1_hit, p0_hit;
   logic        p1_dtack_n, p0_dtack_n;
   logic        p1_berr_n, p0_berr_n;

   int n_tests = 0;
   int n_fail  = 0;

   region_decoder_fsm #(.PRIORITY(1)) dut_p1 (
      .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_data(cfg_data), .cpu_as_n(as_n), .cpu_ds_n(ds_n),
      .cpu_word_addr(addr), .sel_n(p1_sel_n), .hit_idx(p1_idx), .hit(p1_hit),
      .dtack_n(p1_dtack_n), .berr_n(p1_berr_n)
   );

   region_decoder_fsm #(.PRIORITY(0)) dut_p0 (
      .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_data(cfg_data), .cpu_as_n(as_n), .cpu_ds_n(ds_n),
      .cpu_word_addr(addr), .sel_n(p0_sel_n), .hit_idx(p0_idx), .hit(p0_hit),
      .dtack_n(p0_dtack_n), .berr_n(p0_berr_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance n clock edges; leaves time 1 unit after the last rising edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cfg_write(input logic [3:0] idx, input logic en, input logic [3:0] w,
                            input logic [7:0] m, input logic [7:0] k);
      cfg_we   = 1'b1;
      cfg_idx  = idx;
      cfg_data = {en, w, m, k};
      tick(1);
      cfg_we   = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0;
      as_n = 1'b1; ds_n = 2'b11; addr = '0;
      tick(2);
      check("rst_sel",   32'(p1_sel_n),   32'hFFFF);
      check("rst_hit",   32'(p1_hit),     32'h0);
      check("rst_idx",   32'(p1_idx),     32'h0);
      check("rst_dtack", 32'(p1_dtack_n), 32'h1);
      check("rst_berr",  32'(p1_berr_n),  32'h1);
      check("rst_sel_p0", 32'(p0_sel_n),  32'hFFFF);
      reset_n = 1'b1;
      tick(1);

      // Empty table: bus error after BERR_CYCLES
      addr = 24'h000000; as_n = 1'b0; ds_n = 2'b00;
      tick(1);
      check("berr_sel",   32'(p1_sel_n),  32'hFFFF);
      check("berr_hit",   32'(p1_hit),    32'h0);
      check("berr_early", 32'(p1_berr_n), 32'h1);
      tick(63);
      check("berr_pre",   32'(p1_berr_n), 32'h1);
      tick(1);
      check("berr_on",    32'(p1_berr_n), 32'h0);
      check("berr_dtack", 32'(p1_dtack_n), 32'h1);
      tick(2);
      check("berr_hold",  32'(p1_berr_n), 32'h0);
      as_n = 1'b1; ds_n = 2'b11;
      tick(1);
      check("berr_rel",   32'(p1_berr_n), 32'h1);
      tick(1);

      // Single region, zero wait states
      cfg_write(4'd3, 1'b1, 4'd0, 8'h10, 8'hF0);
      addr = 24'h123456; as_n = 1'b0; ds_n = 2'b01;
      tick(1);
      check("e3_sel",    32'(p1_sel_n),   32'hFFF7);
      check("e3_hit",    32'(p1_hit),     32'h1);
      check("e3_idx",    32'(p1_idx),     32'h3);
      check("e3_dtack1", 32'(p1_dtack_n), 32'h1);
      check("e3_sel_p0", 32'(p0_sel_n),   32'hFFF7);
      tick(1);
      check("e3_dtack0", 32'(p1_dtack_n), 32'h0);
      as_n = 1'b1;
      tick(1);
      check("end_sel",   32'(p1_sel_n),   32'hFFFF);
      check("end_hit",   32'(p1_hit),     32'h0);
      check("end_dtack", 32'(p1_dtack_n), 32'h1);
      // Back-to-back: END then IDLE before the next cycle is latched
      as_n = 1'b0;
      tick(1);
      check("b2b_dead",  32'(p1_hit),     32'h0);
      tick(1);
      check("b2b_hit",   32'(p1_hit),     32'h1);
      check("b2b_sel",   32'(p1_sel_n),   32'hFFF7);
      tick(1);
      check("b2b_dtack", 32'(p1_dtack_n), 32'h0);
      as_n = 1'b1;
      tick(2);

      // Overlapping regions 2 (wait 5) and 5 (wait 0, matches all)
      cfg_write(4'd2, 1'b1, 4'd5, 8'h20, 8'hF0);
      cfg_write(4'd5, 1'b1, 4'd0, 8'h00, 8'h00);
      addr = 24'h2ABCDE; as_n = 1'b0; ds_n = 2'b00;
      tick(1);
      check("pri_sel_p1", 32'(p1_sel_n), 32'hFFFB);
      check("pri_idx_p1", 32'(p1_idx),   32'h2);
      check("pri_sel_p0", 32'(p0_sel_n), 32'hFFDB);
      check("pri_idx_p0", 32'(p0_idx),   32'h2);
      check("pri_hit_p0", 32'(p0_hit),   32'h1);
      // Rewrite the active entry while waiting
      cfg_write(4'd2, 1'b1, 4'd1, 8'h30, 8'hF0);
      check("wr_sel_hold", 32'(p1_sel_n), 32'hFFFB);
      tick(4);
      check("pri_dtack6_p1", 32'(p1_dtack_n), 32'h1);
      check("pri_dtack6_p0", 32'(p0_dtack_n), 32'h1);
      tick(1);
      check("pri_dtack7_p1", 32'(p1_dtack_n), 32'h0);
      check("pri_dtack7_p0", 32'(p0_dtack_n), 32'h0);
      check("pri_sel7_p1",   32'(p1_sel_n),   32'hFFFB);
      as_n = 1'b1;
      tick(2);
      as_n = 1'b0;
      tick(1);
      check("new_sel_p1", 32'(p1_sel_n), 32'hFFDF);
      check("new_idx_p1", 32'(p1_idx),   32'h5);
      check("new_sel_p0", 32'(p0_sel_n), 32'hFFDF);
      tick(1);
      check("new_dtack",  32'(p1_dtack_n), 32'h0);

      // Reset while in ACK
      reset_n = 1'b0;
      tick(1);
      check("ackrst_sel",   32'(p1_sel_n),   32'hFFFF);
      check("ackrst_hit",   32'(p1_hit),     32'h0);
      check("ackrst_idx",   32'(p1_idx),     32'h0);
      check("ackrst_dtack", 32'(p1_dtack_n), 32'h1);
      check("ackrst_berr",  32'(p1_berr_n),  32'h1);
      check("ackrst_p0",    32'(p0_dtack_n), 32'h1);
      reset_n = 1'b1;
      tick(1);
      check("post_rst_hit", 32'(p1_hit),   32'h0);
      check("post_rst_sel", 32'(p1_sel_n), 32'hFFFF);
      as_n = 1'b1;
      tick(2);

      // No data strobe: no cycle; then a cycle abandoned during WAIT
      cfg_write(4'd7, 1'b1, 4'd15, 8'h40, 8'hC0);
      addr = 24'h7F0000; as_n = 1'b0; ds_n = 2'b11;
      tick(2);
      check("ds11_hit", 32'(p1_hit), 32'h0);
      ds_n = 2'b10;
      tick(1);
      check("e7_hit", 32'(p1_hit),   32'h1);
      check("e7_idx", 32'(p1_idx),   32'h7);
      check("e7_sel", 32'(p1_sel_n), 32'hFF7F);
      tick(3);
      as_n = 1'b1; ds_n = 2'b11;
      tick(1);
      check("abn_sel",    32'(p1_sel_n),   32'hFFFF);
      check("abn_dtack",  32'(p1_dtack_n), 32'h1);
      tick(1);
      check("abn_dtack2", 32'(p1_dtack_n), 32'h1);

      // Match bit outside mask never hits; early release gives no BERRn
      cfg_write(4'd9, 1'b1, 4'd0, 8'h01, 8'hF0);
      addr = 24'h010000; as_n = 1'b0; ds_n = 2'b00;
      tick(1);
      check("nm_hit", 32'(p1_hit),   32'h0);
      check("nm_sel", 32'(p1_sel_n), 32'hFFFF);
      tick(10);
      as_n = 1'b1; ds_n = 2'b11;
      tick(1);
      check("nm_berr",  32'(p1_berr_n), 32'h1);
      tick(5);
      check("nm_berr2", 32'(p1_berr_n), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
